// File: rtl/acq_pkg.sv
// Shared types and default widths for the acquisition sequencer.
// Also holds the watchdog limit used when ACQ_TIMEOUT_EN is defined.
package acq_pkg;

  localparam int unsigned DefPerW    = 32;
  localparam int unsigned DefRecvW   = 16;
  localparam int unsigned DefDlyW    = 16;
  localparam int unsigned DefTrigW   = 8;
  localparam int unsigned DefTimeout = 65535;

  typedef enum logic [2:0] {
    StIdle,
    StFire,
    StDelay,
    StCapture,
    StHoldoff
  } acq_state_e;

endpackage

// File: rtl/acq_period_timer.sv
// PRF period counter: loads on shot start, then counts down every cycle.
// It stops at zero and flags zero so the sequencer can pace the next trigger.
module acq_period_timer
  import acq_pkg::*;
#(
  parameter int unsigned W = DefPerW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/acq_sequencer.sv
// Pulse-repetition scheduler: trigger, delay, capture handshake, holdoff, frame/overrun flags.
// Define ACQ_TIMEOUT_EN to add the capture watchdog (TIMEOUT parameter, o_timeout flag).
module acq_sequencer
  import acq_pkg::*;
#(
  parameter int unsigned PER_W  = DefPerW,
  parameter int unsigned RECV_W = DefRecvW,
  parameter int unsigned DLY_W  = DefDlyW,
  parameter int unsigned TRIG_W = DefTrigW
`ifdef ACQ_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = DefTimeout
`endif
) (
  input  logic              i_clk_sys,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic              i_single,
  input  logic [PER_W-1:0]  i_prf_period,
  input  logic [DLY_W-1:0]  i_delay,
  input  logic [RECV_W-1:0] i_recv_count,
  input  logic              i_ad_working,
  input  logic              i_clr_flags,
  output logic              o_trig,
  output logic              o_ad_st,
  output logic [RECV_W-1:0] o_recv_count,
  output logic              o_busy,
  output logic [15:0]       o_frame_cnt,
  output logic              o_overrun,
  output logic              o_timeout
);

  localparam int unsigned TcW = (TRIG_W > 1) ? $clog2(TRIG_W) : 1;
  localparam logic [PER_W-1:0] MinPer = PER_W'(TRIG_W + 2);

  acq_state_e       state_q;
  logic             single_q;
  logic             seen_q;
  logic [TcW-1:0]   trig_cnt_q;
  logic [DLY_W-1:0] dly_cnt_q;
  logic [PER_W-1:0] per_load;
  logic             per_zero;
  logic             cap_done;
  logic             cap_exit;
  logic             wd_hit;
  logic             fire_go;

  // Short periods are stretched so trigger plus a minimal gap always fits.
  assign per_load = ((i_prf_period > MinPer) ? i_prf_period : MinPer) - PER_W'(1);

  acq_period_timer #(
    .W(PER_W)
  ) u_period (
    .clk     (i_clk_sys),
    .rst_n   (i_rst_n),
    .load    (fire_go),
    .load_val(per_load),
    .zero    (per_zero)
  );

  always_comb begin
    cap_done = (state_q == StCapture) && seen_q && !i_ad_working;
    cap_exit = cap_done || wd_hit;
    fire_go  = 1'b0;
    case (state_q)
      StIdle:    fire_go = i_enable || i_single;
      StCapture: fire_go = cap_exit && per_zero && i_enable && !single_q;
      StHoldoff: fire_go = per_zero && i_enable && !single_q;
      default:   fire_go = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk_sys) begin
    if (!i_rst_n) begin
      state_q      <= StIdle;
      single_q     <= 1'b0;
      seen_q       <= 1'b0;
      trig_cnt_q   <= '0;
      dly_cnt_q    <= '0;
      o_trig       <= 1'b0;
      o_ad_st      <= 1'b0;
      o_recv_count <= '0;
      o_busy       <= 1'b0;
      o_frame_cnt  <= '0;
      o_overrun    <= 1'b0;
    end else begin
      o_ad_st <= 1'b0;
      // A zero period count seen during capture means the next trigger is already late.
      if ((state_q == StCapture) && per_zero) begin
        o_overrun <= 1'b1;
      end else if (i_clr_flags) begin
        o_overrun <= 1'b0;
      end

      case (state_q)
        StFire: begin
          if (trig_cnt_q == '0) begin
            o_trig <= 1'b0;
            if (dly_cnt_q == '0) begin
              state_q <= StCapture;
              o_ad_st <= 1'b1;
              seen_q  <= 1'b0;
            end else begin
              state_q <= StDelay;
            end
          end else begin
            trig_cnt_q <= trig_cnt_q - TcW'(1);
          end
        end
        StDelay: begin
          if (dly_cnt_q == DLY_W'(1)) begin
            state_q <= StCapture;
            o_ad_st <= 1'b1;
            seen_q  <= 1'b0;
          end else begin
            dly_cnt_q <= dly_cnt_q - DLY_W'(1);
          end
        end
        StCapture: begin
          if (i_ad_working) begin
            seen_q <= 1'b1;
          end
          if (cap_exit) begin
            if (cap_done) begin
              o_frame_cnt <= o_frame_cnt + 16'd1;
            end
            state_q <= per_zero ? StIdle : StHoldoff;
            o_busy  <= !per_zero;
          end
        end
        StHoldoff: begin
          if (per_zero) begin
            state_q <= StIdle;
            o_busy  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Shot start overrides whatever the state branch chose.
      if (fire_go) begin
        state_q      <= StFire;
        o_trig       <= 1'b1;
        o_busy       <= 1'b1;
        trig_cnt_q   <= TcW'(TRIG_W - 1);
        dly_cnt_q    <= i_delay;
        o_recv_count <= i_recv_count;
        if (state_q == StIdle) begin
          single_q <= !i_enable;
        end
      end
    end
  end

`ifdef ACQ_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT + 1);

  logic [WdW-1:0] wd_q;

  always_ff @(posedge i_clk_sys) begin
    if (!i_rst_n || (state_q != StCapture)) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + WdW'(1);
    end
  end

  // A normal completion in the same cycle wins over the watchdog.
  assign wd_hit = (state_q == StCapture) && !cap_done && (wd_q == WdW'(TIMEOUT - 1));

  always_ff @(posedge i_clk_sys) begin
    if (!i_rst_n) begin
      o_timeout <= 1'b0;
    end else if (wd_hit) begin
      o_timeout <= 1'b1;
    end else if (i_clr_flags) begin
      o_timeout <= 1'b0;
    end
  end
`else
  assign wd_hit    = 1'b0;
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_acq_sequencer.sv
// Self-checking bench for acq_sequencer: randomized shots against an arithmetic timing model.
module tb_acq_sequencer;

  localparam int TrigW = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        single = 1'b0;
  logic        clr = 1'b0;
  logic        working = 1'b0;
  logic [31:0] prf = 32'd100;
  logic [15:0] dly = 16'd0;
  logic [15:0] recv = 16'd0;
  logic        trig, ad_st, busy, overrun, timeout;
  logic [15:0] recv_o, frame;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_frames = 0;
  int trig_q[$], width_q[$], ad_q[$], idle_q[$], fall_q[$];
  int trig_start = 0;
  logic trig_prev = 1'b0;
  logic busy_prev = 1'b0;
  int work_gap = 0;
  int work_lo = 1;
  int work_hi = 1;
  bit work_abort = 1'b0;

  acq_sequencer #(
    .PER_W (32),
    .RECV_W(16),
    .DLY_W (16),
    .TRIG_W(TrigW)
`ifdef ACQ_TIMEOUT_EN
    ,
    .TIMEOUT(100)
`endif
  ) dut (
    .i_clk_sys   (clk),
    .i_rst_n     (rst_n),
    .i_enable    (enable),
    .i_single    (single),
    .i_prf_period(prf),
    .i_delay     (dly),
    .i_recv_count(recv),
    .i_ad_working(working),
    .i_clr_flags (clr),
    .o_trig      (trig),
    .o_ad_st     (ad_st),
    .o_recv_count(recv_o),
    .o_busy      (busy),
    .o_frame_cnt (frame),
    .o_overrun   (overrun),
    .o_timeout   (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe DUT events at the falling edge, tagged with the current cycle index.
  always @(negedge clk) begin
    if (trig && !trig_prev) begin
      trig_q.push_back(cyc);
      trig_start = cyc;
    end
    if (!trig && trig_prev) width_q.push_back(cyc - trig_start);
    if (ad_st) ad_q.push_back(cyc);
    if (!busy && busy_prev) idle_q.push_back(cyc);
    trig_prev = trig;
    busy_prev = busy;
  end

  // Capture wrapper stand-in: busy for a random spell after each start strobe.
  always begin
    @(negedge clk);
    if (ad_st) begin
      int h;
      h = $urandom_range(work_hi, work_lo);
      repeat (work_gap) @(negedge clk);
      working = 1'b1;
      for (int k = 0; k < h && !work_abort; k++) @(negedge clk);
      working = 1'b0;
      fall_q.push_back(cyc);
    end
  end

  // Model: next trigger (or return to idle) is the later of period expiry and capture end + 1.
  function automatic int next_start(input int t, input int f, input int pe);
    return (t + pe > f + 1) ? t + pe : f + 1;
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clear_queues();
    trig_q.delete();
    width_q.delete();
    ad_q.delete();
    idle_q.delete();
    fall_q.delete();
  endtask

  task automatic test_reset_init();
    step(2);
    checks++;
    if ({trig, ad_st, busy, overrun, timeout, recv_o, frame} !== '0) begin
      errors++;
      $display("FAIL reset_init: outputs %h, want 0",
               {trig, ad_st, busy, overrun, timeout, recv_o, frame});
    end
    rst_n = 1'b1;
    step(3);
    checks++;
    if ({busy, trig, frame} !== '0) begin
      errors++;
      $display("FAIL reset_release_idle: busy/trig/frame %h, want 0", {busy, trig, frame});
    end
  endtask

  task automatic test_free_run();
    int per, pe, d, n, t_exp, b;
    bit ovr_exp;
    logic [15:0] rc;
    for (int c = 0; c < 3; c++) begin
      per = (c == 0) ? 1000 : $urandom_range(400, 4);
      d = (c == 0) ? 20 : ((c == 1) ? $urandom_range(30, 1) : 0);
      work_lo = (c == 0) ? 300 : 1;
      work_hi = (c == 0) ? 300 : $urandom_range(400, 20);
      work_gap = (c == 0) ? 0 : $urandom_range(3, 0);
      n = 4;
      pe = (per > TrigW + 2) ? per : TrigW + 2;
      rc = 16'($urandom);
      prf = per;
      dly = 16'(d);
      recv = rc;
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      clear_queues();
      enable = 1'b1;
      t_exp = cyc + 1;
      b = 0;
      while (trig_q.size() < n && b < 20000) begin
        step(1);
        b++;
      end
      enable = 1'b0;
      b = 0;
      while (idle_q.size() == 0 && b < 20000) begin
        step(1);
        b++;
      end
      checks++;
      if (trig_q.size() != n || ad_q.size() != n || fall_q.size() != n ||
          width_q.size() != n || idle_q.size() != 1) begin
        errors++;
        $display("FAIL free_run_counts cfg%0d: trig %0d ad %0d idle %0d, want %0d %0d 1",
                 c, trig_q.size(), ad_q.size(), idle_q.size(), n, n);
      end else begin
        ovr_exp = 1'b0;
        for (int i = 0; i < n; i++) begin
          checks++;
          if (trig_q[i] !== t_exp) begin
            errors++;
            $display("FAIL free_run_trig cfg%0d shot%0d: cycle %0d, want %0d",
                     c, i, trig_q[i], t_exp);
          end
          checks++;
          if (ad_q[i] !== t_exp + TrigW + d) begin
            errors++;
            $display("FAIL free_run_ad_st cfg%0d shot%0d: cycle %0d, want %0d",
                     c, i, ad_q[i], t_exp + TrigW + d);
          end
          checks++;
          if (width_q[i] !== TrigW) begin
            errors++;
            $display("FAIL free_run_trig_width cfg%0d shot%0d: %0d, want %0d",
                     c, i, width_q[i], TrigW);
          end
          if (t_exp + pe - 1 <= fall_q[i]) ovr_exp = 1'b1;
          t_exp = next_start(t_exp, fall_q[i], pe);
        end
        checks++;
        if (idle_q[0] !== t_exp) begin
          errors++;
          $display("FAIL free_run_idle cfg%0d: busy fell at %0d, want %0d", c, idle_q[0], t_exp);
        end
        checks++;
        if (overrun !== ovr_exp) begin
          errors++;
          $display("FAIL free_run_overrun cfg%0d: %b, want %b", c, overrun, ovr_exp);
        end
      end
      exp_frames += n;
      checks++;
      if (frame !== 16'(exp_frames) || recv_o !== rc) begin
        errors++;
        $display("FAIL free_run_frame cfg%0d: frame %0d recv %0d, want %0d %0d",
                 c, frame, recv_o, exp_frames, rc);
      end
    end
  endtask

  task automatic test_single();
    int t, b;
    prf = 150;
    dly = 3;
    work_lo = 1;
    work_hi = 60;
    work_gap = $urandom_range(3, 0);
    clear_queues();
    single = 1'b1;
    t = cyc + 1;
    step(1);
    single = 1'b0;
    step(30);
    single = 1'b1;
    step(1);
    single = 1'b0;
    b = 0;
    while (idle_q.size() == 0 && b < 5000) begin
      step(1);
      b++;
    end
    step(50);
    exp_frames++;
    checks++;
    if (trig_q.size() != 1 || ad_q.size() != 1 || fall_q.size() != 1 || idle_q.size() != 1) begin
      errors++;
      $display("FAIL single_counts: trig %0d ad %0d idle %0d, want 1 1 1",
               trig_q.size(), ad_q.size(), idle_q.size());
    end else begin
      checks++;
      if (trig_q[0] !== t || ad_q[0] !== t + TrigW + 3) begin
        errors++;
        $display("FAIL single_timing: trig %0d ad %0d, want %0d %0d",
                 trig_q[0], ad_q[0], t, t + TrigW + 3);
      end
      checks++;
      if (idle_q[0] !== next_start(t, fall_q[0], 150)) begin
        errors++;
        $display("FAIL single_idle: busy fell at %0d, want %0d",
                 idle_q[0], next_start(t, fall_q[0], 150));
      end
    end
    checks++;
    if (busy !== 1'b0 || frame !== 16'(exp_frames)) begin
      errors++;
      $display("FAIL single_end: busy %b frame %0d, want 0 %0d", busy, frame, exp_frames);
    end
  endtask

  task automatic test_overrun();
    int t, b;
    prf = 200;
    dly = 20;
    work_lo = 500;
    work_hi = 500;
    work_gap = 0;
    clear_queues();
    enable = 1'b1;
    t = cyc + 1;
    step(250);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set_wins: overrun %b, want 1", overrun);
    end
    b = 0;
    while (trig_q.size() < 2 && b < 5000) begin
      step(1);
      b++;
    end
    enable = 1'b0;
    b = 0;
    while (idle_q.size() == 0 && b < 5000) begin
      step(1);
      b++;
    end
    exp_frames += 2;
    checks++;
    if (trig_q.size() != 2 || fall_q.size() != 2 || idle_q.size() != 1) begin
      errors++;
      $display("FAIL overrun_counts: trig %0d fall %0d idle %0d, want 2 2 1",
               trig_q.size(), fall_q.size(), idle_q.size());
    end else begin
      checks++;
      if (trig_q[1] !== fall_q[0] + 1 || trig_q[0] !== t) begin
        errors++;
        $display("FAIL overrun_retrigger: trig %0d/%0d, want %0d/%0d",
                 trig_q[0], trig_q[1], t, fall_q[0] + 1);
      end
      checks++;
      if (idle_q[0] !== fall_q[1] + 1) begin
        errors++;
        $display("FAIL overrun_idle: busy fell at %0d, want %0d", idle_q[0], fall_q[1] + 1);
      end
    end
    checks++;
    if (overrun !== 1'b1 || frame !== 16'(exp_frames)) begin
      errors++;
      $display("FAIL overrun_end: overrun %b frame %0d, want 1 %0d", overrun, frame, exp_frames);
    end
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    step(1);
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: overrun %b, want 0", overrun);
    end
  endtask

  task automatic test_reconfig();
    int b;
    prf = 100;
    dly = 2;
    work_lo = 100;
    work_hi = 100;
    work_gap = 1;
    recv = 16'd8000;
    clear_queues();
    single = 1'b1;
    step(1);
    single = 1'b0;
    b = 0;
    while (ad_q.size() == 0 && b < 1000) begin
      step(1);
      b++;
    end
    recv = 16'd4000;
    step(5);
    checks++;
    if (recv_o !== 16'd8000) begin
      errors++;
      $display("FAIL reconfig_mid_capture: recv_count %0d, want 8000", recv_o);
    end
    b = 0;
    while (idle_q.size() == 0 && b < 2000) begin
      step(1);
      b++;
    end
    checks++;
    if (recv_o !== 16'd8000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reconfig_after_shot: recv_count %0d busy %b, want 8000 0", recv_o, busy);
    end
    clear_queues();
    single = 1'b1;
    step(1);
    single = 1'b0;
    step(3);
    checks++;
    if (recv_o !== 16'd4000) begin
      errors++;
      $display("FAIL reconfig_next_shot: recv_count %0d, want 4000", recv_o);
    end
    b = 0;
    while (idle_q.size() == 0 && b < 2000) begin
      step(1);
      b++;
    end
    exp_frames += 2;
    checks++;
    if (frame !== 16'(exp_frames)) begin
      errors++;
      $display("FAIL reconfig_frames: frame %0d, want %0d", frame, exp_frames);
    end
  endtask

  task automatic test_reset_mid();
    int b;
    prf = 500;
    dly = 4;
    work_lo = 5000;
    work_hi = 5000;
    work_gap = 0;
    clear_queues();
    single = 1'b1;
    step(1);
    single = 1'b0;
    b = 0;
    while (ad_q.size() == 0 && b < 1000) begin
      step(1);
      b++;
    end
    step(10);
    checks++;
    if (busy !== 1'b1 || working !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_precondition: busy %b working %b, want 1 1", busy, working);
    end
    rst_n = 1'b0;
    step(1);
    checks++;
    if ({trig, ad_st, busy, overrun, timeout, recv_o, frame} !== '0) begin
      errors++;
      $display("FAIL reset_mid_capture: outputs %h, want 0",
               {trig, ad_st, busy, overrun, timeout, recv_o, frame});
    end
    step(1);
    rst_n = 1'b1;
    work_abort = 1'b1;
    step(2);
    work_abort = 1'b0;
    exp_frames = 0;
    clear_queues();
    step(30);
    checks++;
    if (busy !== 1'b0 || trig_q.size() != 0 || frame !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid_stays_idle: busy %b trigs %0d frame %0d, want 0 0 0",
               busy, trig_q.size(), frame);
    end
  endtask

  task automatic test_timeout();
    int t, c_st, b;
    prf = 1000;
    dly = 5;
    work_lo = 5000;
    work_hi = 5000;
    work_gap = 0;
    clear_queues();
    single = 1'b1;
    t = cyc + 1;
    step(1);
    single = 1'b0;
    b = 0;
    while (ad_q.size() == 0 && b < 1000) begin
      step(1);
      b++;
    end
    checks++;
    if (ad_q.size() != 1) begin
      errors++;
      $display("FAIL timeout_start: strobes %0d, want 1", ad_q.size());
    end
    c_st = (ad_q.size() > 0) ? ad_q[0] : cyc;
`ifdef ACQ_TIMEOUT_EN
    while (cyc < c_st + 100) step(1);
    checks++;
    if (timeout !== 1'b1 || busy !== 1'b1 || frame !== 16'(exp_frames)) begin
      errors++;
      $display("FAIL timeout_fire: timeout %b busy %b frame %0d, want 1 1 %0d",
               timeout, busy, frame, exp_frames);
    end
    b = 0;
    while (idle_q.size() == 0 && b < 3000) begin
      step(1);
      b++;
    end
    checks++;
    if (idle_q.size() != 1 || frame !== 16'(exp_frames)) begin
      errors++;
      $display("FAIL timeout_idle: idle events %0d frame %0d, want 1 %0d",
               idle_q.size(), frame, exp_frames);
    end else begin
      checks++;
      if (idle_q[0] !== next_start(t, c_st + 99, 1000)) begin
        errors++;
        $display("FAIL timeout_idle_time: %0d, want %0d",
                 idle_q[0], next_start(t, c_st + 99, 1000));
      end
    end
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    step(1);
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: timeout %b, want 0", timeout);
    end
    work_abort = 1'b1;
    step(2);
    work_abort = 1'b0;
`else
    while (cyc < c_st + 150) step(1);
    checks++;
    if (busy !== 1'b1 || timeout !== 1'b0 || frame !== 16'(exp_frames) || idle_q.size() != 0) begin
      errors++;
      $display("FAIL no_timeout_waits: busy %b timeout %b frame %0d, want 1 0 %0d",
               busy, timeout, frame, exp_frames);
    end
    checks++;
    if (t + TrigW + 5 !== c_st) begin
      errors++;
      $display("FAIL no_timeout_strobe: cycle %0d, want %0d", c_st, t + TrigW + 5);
    end
`endif
  endtask

  initial begin
    test_reset_init();
    test_free_run();
    test_single();
    test_overrun();
    test_reconfig();
    test_reset_mid();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
